// File: rtl/mem_read_responder.sv
// mem_read_responder: memory-side responder for the cache fill interface.
// One word request per cycle; reads return LATENCY cycles later through a
// valid/data/addr pipeline that freezes while stall is high.
module mem_read_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  input  logic              stall,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy
);

  localparam int          WORDS = 2 ** (ADDR_W - 1);
  localparam int          CNT_W = $clog2(LATENCY + 1);
  localparam int unsigned LAST  = LATENCY - 1;

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("mem_read_responder: LATENCY must be in 1..8");
  end

  logic [15:0]       mem [WORDS];

  logic              v_q [LATENCY];
  logic [15:0]       d_q [LATENCY];
  logic [ADDR_W-1:0] a_q [LATENCY];
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-2:0] word_idx;
  logic [ADDR_W-1:0] aligned_addr;
  logic [15:0]       rd_word;
  logic              accept;
  logic              accept_rd;
  logic              retire;

  assign word_idx     = addr[ADDR_W-1:1];
  assign aligned_addr = addr & ~ADDR_W'(1);
  assign rd_word      = mem[word_idx];
  assign accept       = enable && !stall;
  assign accept_rd    = accept && !wr;
  assign retire       = v_q[LAST] && !stall;

  // Array write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[word_idx] <= data_in;
    end
  end

  // Read pipeline: data is captured at issue, so later writes cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        a_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q[0] <= accept_rd;
      d_q[0] <= accept_rd ? rd_word : '0;
      a_q[0] <= accept_rd ? aligned_addr : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
        a_q[i] <= a_q[i-1];
      end
    end
  end

  // In-flight read counter; issue and retire in the same cycle cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({accept_rd, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_out   = d_q[LAST];
  assign rsp_addr   = a_q[LAST];
  assign data_valid = v_q[LAST] && !stall;
  assign busy       = (count != '0);

endmodule

// File: tb/tb_mem_read_responder.sv
// Testbench for mem_read_responder: table-driven per-cycle vectors plus
// hand-written stall-burst and reset-mid-fill sequences.
module tb_mem_read_responder;

    localparam int LAT = 4;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          wr;
    logic [AW-1:0] addr;
    logic [15:0]   data_in;
    logic          stall;
    logic [15:0]   data_out;
    logic          data_valid;
    logic [AW-1:0] rsp_addr;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_read_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .stall      (stall),
        .data_out   (data_out),
        .data_valid (data_valid),
        .rsp_addr   (rsp_addr),
        .busy       (busy)
    );

    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stall;
        logic        e_valid;
        logic        e_busy;
        logic        chk_d;
        logic [15:0] e_data;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic st, input logic ev,
                       input logic eb, input logic cd, input logic [15:0] ed,
                       input logic [15:0] ea);
        vec_t v;
        v.en = en; v.wr = w; v.addr = a; v.din = d; v.stall = st;
        v.e_valid = ev; v.e_busy = eb; v.chk_d = cd; v.e_data = ed; v.e_addr = ea;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic st);
        enable = en; wr = w; addr = a; data_in = d; stall = st;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic eb,
                             input logic cd, input logic [15:0] ed,
                             input logic [15:0] ea);
        checks++;
        if (data_valid !== ev) begin
            errors++;
            $display("FAIL %s data_valid: got %0b want %0b", tag, data_valid, ev);
        end
        checks++;
        if (busy !== eb) begin
            errors++;
            $display("FAIL %s busy: got %0b want %0b", tag, busy, eb);
        end
        if (cd) begin
            checks++;
            if (data_out !== ed) begin
                errors++;
                $display("FAIL %s data_out: got %h want %h", tag, data_out, ed);
            end
            checks++;
            if (rsp_addr !== ea) begin
                errors++;
                $display("FAIL %s rsp_addr: got %h want %h", tag, rsp_addr, ea);
            end
        end
        // In-flight counter must stay within 0..LAT (a wrap shows up as > LAT).
        checks++;
        if (int'(dut.count) > LAT) begin
            errors++;
            $display("FAIL %s count_bound: got %0d want <= %0d", tag, dut.count, LAT);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ew [16];
        logic [15:0] rr_addr [3];
        logic [15:0] rr_data [3];

        // ---------------- vector table ----------------
        // idle after reset
        for (int i = 0; i < 10; i++) add(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000);
        // single read of 0x0020 = BEEF
        add(1, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 16'hBEEF, 16'h0020);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // read with 2 stall cycles; a write presented during stall is ignored
        add(1, 0, 16'h0021, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 16'h0020, 16'hDEAD, 1, 0, 1, 0, 0, 0);
        add(1, 1, 16'h0020, 16'hDEAD, 1, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 16'hBEEF, 16'h0020);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reread confirms the stalled write had no effect
        add(1, 0, 16'h0020, 16'h0000, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 16'hBEEF, 16'h0020);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // write-after-read ordering on 0x0040
        add(1, 1, 16'h0040, 16'h1111, 0, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0040, 16'h0000, 0, 0, 0, 0, 0, 0);
        add(1, 1, 16'h0040, 16'h2222, 0, 0, 1, 0, 0, 0);
        add(1, 0, 16'h0040, 16'h0000, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 16'h1111, 16'h0040);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 1, 16'h2222, 16'h0040);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // preload 0x0100..0x010E with A000..A007, then 8-word fill
        for (int i = 0; i < 8; i++)
            add(1, 1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i), 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++)
            add(k < 8, 0, 16'(16'h0100 + 2 * k), 16'h0000, 0,
                (k >= 4 && k <= 11), (k >= 1 && k <= 11), (k >= 4 && k <= 11),
                16'(16'hA000 + k - 4), 16'(16'h0100 + 2 * (k - 4)));

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(0, 0, 16'h0000, 16'h0000, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("reset_state", 0, 0, 1, 16'h0000, 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].stall);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_busy,
                      vecs[i].chk_d, vecs[i].e_data, vecs[i].e_addr);
            next_cycle();
        end

        // ---------------- stall mid-burst ----------------
        // Requester holds word 5 while stalled (cycles 5..7), then finishes.
        ew = '{-1, -1, -1, -1, 0, -1, -1, -1, 1, 2, 3, 4, 5, 6, 7, -1};
        for (int c = 0; c < 16; c++) begin
            logic st;
            int   w;
            st = (c >= 5 && c <= 7);
            if (c <= 4)       w = c;
            else if (c <= 7)  w = 5;
            else if (c <= 10) w = c - 3;
            else              w = -1;
            if (w >= 0) drive(1, 0, 16'(16'h0100 + 2 * w), 16'h0000, st);
            else        drive(0, 0, 16'h0000, 16'h0000, st);
            #1;
            if (ew[c] >= 0)
                check_out($sformatf("stall_burst_c%0d", c), 1, 1, 1,
                          16'(16'hA000 + ew[c]), 16'(16'h0100 + 2 * ew[c]));
            else if (st)
                check_out($sformatf("stall_hold_c%0d", c), 0, 1, 1, 16'hA001, 16'h0102);
            else
                check_out($sformatf("stall_burst_c%0d", c), 0, (c >= 1 && c <= 14), 0, 0, 0);
            next_cycle();
        end

        // ---------------- reset mid-fill ----------------
        drive(1, 0, 16'h0100, 16'h0000, 0);
        #1;
        check_out("rstfill_c0", 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 16'h0102, 16'h0000, 0);
        #1;
        check_out("rstfill_c1", 0, 1, 0, 0, 0);
        next_cycle();
        drive(1, 0, 16'h0104, 16'h0000, 0);
        rst_n = 1'b0;
        #1;
        check_out("rstfill_in_reset", 0, 0, 1, 16'h0000, 16'h0000);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 16'h0000, 16'h0000, 0);
        for (int c = 0; c < 8; c++) begin
            #1;
            check_out($sformatf("rstfill_after_c%0d", c), 0, 0, 1, 16'h0000, 16'h0000);
            next_cycle();
        end

        // reread values written before the reset
        rr_addr = '{16'h0020, 16'h010E, 16'h0040};
        rr_data = '{16'hBEEF, 16'hA007, 16'h2222};
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1, 0, rr_addr[c], 16'h0000, 0);
            else       drive(0, 0, 16'h0000, 16'h0000, 0);
            #1;
            if (c >= 4 && c <= 6)
                check_out($sformatf("reread_c%0d", c), 1, 1, 1, rr_data[c-4], rr_addr[c-4]);
            else
                check_out($sformatf("reread_c%0d", c), 0, (c >= 1 && c <= 6), 0, 0, 0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
